// File: rtl/command_arbiter_rr.sv
// -----------------------------------------------------------------------------
// command_arbiter_rr
//
// Round-robin arbiter that shares the single PSL command interface among the
// AFU command sources (0 = WED, 1 = read, 2 = write, 3 = restart). Each cycle
// at most one requester is granted, gated by a PSL command-credit counter.
// The granted command is registered toward the PSL one cycle after the grant,
// stamped with an 8-bit wrapping tag. A saturating issue counter and a sticky
// credit-error flag are kept for debug.
//
// Configuration macro:
//   CMD_ARB_WED_PRIORITY_EN  defined   -> requester 0 (WED) wins whenever it
//                                         requests; the rr pointer is left
//                                         untouched on such a grant.
//                            undefined -> pure round-robin over all requesters.
//
// Ports:
//   clock             in   system clock
//   rstn              in   asynchronous active-low reset
//   enabled_in        in   job running; no grants while low
//   req_valid         in   [NUM_REQ]        requester i holds a command
//   req_cmd           in   [NUM_REQ*CMD_W]  payload i at [i*CMD_W +: CMD_W]
//   req_grant         out  [NUM_REQ]        one-hot pop strobe (combinational)
//   command_valid     out  registered command strobe to PSL
//   command_payload   out  [CMD_W]          registered payload of the winner
//   command_tag       out  [8]              tag attached to the payload
//   command_src       out  [2]              index of the granted requester
//   response_valid    in   PSL response; returns one credit
//   credits_available out  [CREDIT_W]       current credit count
//   issued_count      out  [32]             commands issued, saturating
//   credit_error      out  sticky: credit returned while already full
// -----------------------------------------------------------------------------
module command_arbiter_rr #(
   parameter int NUM_REQ     = 4,
   parameter int CMD_W       = 96,
   parameter int MAX_CREDITS = 64,
   parameter int CREDIT_W    = 7
) (
   input  logic                     clock,
   input  logic                     rstn,
   input  logic                     enabled_in,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
   output logic [NUM_REQ-1:0]       req_grant,
   output logic                     command_valid,
   output logic [CMD_W-1:0]         command_payload,
   output logic [7:0]               command_tag,
   output logic [1:0]               command_src,
   input  logic                     response_valid,
   output logic [CREDIT_W-1:0]      credits_available,
   output logic [31:0]              issued_count,
   output logic                     credit_error
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [CREDIT_W-1:0] CREDITS_FULL = CREDIT_W'(MAX_CREDITS);
   localparam logic [PTR_W-1:0]    PTR_RST      = PTR_W'(NUM_REQ - 1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [PTR_W-1:0]    ptr_q,             ptr_d;
   logic [CREDIT_W-1:0] credits_q,         credits_d;
   logic [7:0]          tag_cnt_q,         tag_cnt_d;
   logic [31:0]         issued_q,          issued_d;
   logic                credit_error_q,    credit_error_d;
   logic                command_valid_q,   command_valid_d;
   logic [CMD_W-1:0]    command_payload_q, command_payload_d;
   logic [7:0]          command_tag_q,     command_tag_d;
   logic [1:0]          command_src_q,     command_src_d;

   // ---------------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------------
   logic [PTR_W-1:0] rr_winner;
   logic             rr_found;
   logic [PTR_W-1:0] cand;
   logic [PTR_W-1:0] winner;
   logic             wed_prio;
   logic             grant_ok;
   logic [CMD_W-1:0] winner_cmd;

   // Search upward from the requester after the last winner, wrapping, so
   // the most recently served requester is considered last.
   always_comb begin
      // NOTE: every variable assigned in a combinational block gets a default
      // first; a path that skips an assignment would otherwise infer a latch.
      rr_winner = '0;
      rr_found  = 1'b0;
      cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
         if (!rr_found && req_valid[cand]) begin
            rr_found  = 1'b1;
            rr_winner = cand;
         end
      end
   end

   always_comb begin
      winner   = rr_winner;
      wed_prio = 1'b0;
`ifdef CMD_ARB_WED_PRIORITY_EN
      // WED jumps the queue; the others keep rotating among themselves
      // because the pointer is not moved by a WED grant.
      if (req_valid[0]) begin
         winner   = '0;
         wed_prio = 1'b1;
      end
`endif
   end

   // rstn is part of the gate so no pop strobe escapes while in reset.
   assign grant_ok  = rstn && enabled_in && (credits_q != '0) && rr_found;
   assign req_grant = grant_ok ? (NUM_REQ'(1) << winner) : '0;

   always_comb begin
      winner_cmd = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (PTR_W'(i) == winner) begin
            winner_cmd = req_cmd[i*CMD_W +: CMD_W];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      ptr_d             = ptr_q;
      tag_cnt_d         = tag_cnt_q;
      issued_d          = issued_q;
      command_valid_d   = grant_ok;
      command_payload_d = command_payload_q;
      command_tag_d     = command_tag_q;
      command_src_d     = command_src_q;

      if (grant_ok) begin
         if (!wed_prio) begin
            ptr_d = winner;
         end
         command_payload_d = winner_cmd;
         command_src_d     = 2'(winner);
         command_tag_d     = tag_cnt_q;
         tag_cnt_d         = tag_cnt_q + 8'd1;
         if (issued_q != 32'hFFFF_FFFF) begin
            issued_d = issued_q + 32'd1;
         end
      end
   end

   // A grant and a response in the same cycle cancel. A response with no
   // outstanding credit to return is a PSL protocol error: hold the count.
   always_comb begin
      credits_d      = credits_q;
      credit_error_d = credit_error_q;
      if (grant_ok && !response_valid) begin
         credits_d = credits_q - CREDIT_W'(1);
      end else if (!grant_ok && response_valid) begin
         if (credits_q == CREDITS_FULL) begin
            credit_error_d = 1'b1;
         end else begin
            credits_d = credits_q + CREDIT_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         ptr_q             <= PTR_RST;
         credits_q         <= CREDITS_FULL;
         tag_cnt_q         <= '0;
         issued_q          <= '0;
         credit_error_q    <= 1'b0;
         command_valid_q   <= 1'b0;
         command_payload_q <= '0;
         command_tag_q     <= '0;
         command_src_q     <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples its _d value from before this edge, independent of order.
         ptr_q             <= ptr_d;
         credits_q         <= credits_d;
         tag_cnt_q         <= tag_cnt_d;
         issued_q          <= issued_d;
         credit_error_q    <= credit_error_d;
         command_valid_q   <= command_valid_d;
         command_payload_q <= command_payload_d;
         command_tag_q     <= command_tag_d;
         command_src_q     <= command_src_d;
      end
   end

   assign command_valid     = command_valid_q;
   assign command_payload   = command_payload_q;
   assign command_tag       = command_tag_q;
   assign command_src       = command_src_q;
   assign credits_available = credits_q;
   assign issued_count      = issued_q;
   assign credit_error      = credit_error_q;

endmodule

// File: tb/tb_command_arbiter_rr.sv
module tb_command_arbiter_rr;

   localparam int NUM_REQ = 4;
   localparam int CMD_W   = 96;
   localparam int MAXC    = 64;

   typedef struct packed {
      logic [CMD_W-1:0] payload;
      logic [1:0]       src;
      logic [7:0]       tag;
   } exp_t;

   logic                     clock = 1'b0;
   logic                     rstn;
   logic                     enabled_in;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*CMD_W-1:0] req_cmd;
   logic [NUM_REQ-1:0]       req_grant;
   logic                     command_valid;
   logic [CMD_W-1:0]         command_payload;
   logic [7:0]               command_tag;
   logic [1:0]               command_src;
   logic                     response_valid;
   logic [6:0]               credits_available;
   logic [31:0]              issued_count;
   logic                     credit_error;

   int checks   = 0;
   int failures = 0;

   // reference model state
   int     m_ptr;
   int     m_credits;
   int     m_tag;
   longint m_issued;
   bit     m_err;
   exp_t   exp_q[$];
   int     src_log[$];
   int     tag_log[$];

   always #5 clock = ~clock;

   command_arbiter_rr dut (
      .clock             (clock),
      .rstn              (rstn),
      .enabled_in        (enabled_in),
      .req_valid         (req_valid),
      .req_cmd           (req_cmd),
      .req_grant         (req_grant),
      .command_valid     (command_valid),
      .command_payload   (command_payload),
      .command_tag       (command_tag),
      .command_src       (command_src),
      .response_valid    (response_valid),
      .credits_available (credits_available),
      .issued_count      (issued_count),
      .credit_error      (credit_error)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Winner choice by the bench model; -1 when nobody requests.
   function automatic int model_pick(input logic [3:0] v, input int ptr, output bit prio);
      logic [1:0] c;
      prio = 1'b0;
`ifdef CMD_ARB_WED_PRIORITY_EN
      if (v[0]) begin
         prio = 1'b1;
         return 0;
      end
`endif
      for (int k = 1; k <= NUM_REQ; k++) begin
         c = 2'((ptr + k) % NUM_REQ);
         if (v[c]) return int'(c);
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr     = NUM_REQ - 1;
      m_credits = MAXC;
      m_tag     = 0;
      m_issued  = 0;
      m_err     = 1'b0;
      exp_q.delete();
      src_log.delete();
      tag_log.delete();
   endtask

   // One clock cycle: drive at negedge, check grant, model update, check
   // registered outputs just after the posedge, end at next negedge.
   task automatic cycle(input logic [3:0] v, input logic en, input logic resp);
      int         w;
      bit         prio;
      logic [3:0] eg;
      exp_t       e;
      req_valid      = v;
      enabled_in     = en;
      response_valid = resp;
      for (int i = 0; i < NUM_REQ; i++) req_cmd[i*CMD_W +: CMD_W] = {$urandom, $urandom, $urandom};
      #1;
      w    = -1;
      prio = 1'b0;
      eg   = '0;
      if (en && m_credits != 0) w = model_pick(v, m_ptr, prio);
      if (w >= 0) eg = 4'b0001 << w;
      checks++;
      if (req_grant !== eg) begin
         failures++;
         $display("FAIL req_grant: got %b expected %b", req_grant, eg);
      end
      if (w >= 0) begin
         e.payload = req_cmd[w*CMD_W +: CMD_W];
         e.src     = 2'(w);
         e.tag     = 8'(m_tag);
         exp_q.push_back(e);
         m_tag = (m_tag + 1) % 256;
         if (m_issued < 64'hFFFF_FFFF) m_issued++;
         if (!prio) m_ptr = w;
      end
      if (w >= 0 && !resp) m_credits--;
      else if (w < 0 && resp) begin
         if (m_credits == MAXC) m_err = 1'b1;
         else m_credits++;
      end
      @(posedge clock);
      #1;
      checks++;
      if (command_valid !== (w >= 0)) begin
         failures++;
         $display("FAIL command_valid: got %b expected %b", command_valid, (w >= 0));
      end
      if (command_valid === 1'b1) begin
         src_log.push_back(int'(command_src));
         tag_log.push_back(int'(command_tag));
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (command_payload !== e.payload) begin
               failures++;
               $display("FAIL command_payload: got %h expected %h", command_payload, e.payload);
            end
            checks++;
            if (command_src !== e.src) begin
               failures++;
               $display("FAIL command_src: got %0d expected %0d", command_src, e.src);
            end
            checks++;
            if (command_tag !== e.tag) begin
               failures++;
               $display("FAIL command_tag: got %0d expected %0d", command_tag, e.tag);
            end
         end
      end
      checks++;
      if (credits_available !== 7'(m_credits)) begin
         failures++;
         $display("FAIL credits_available: got %0d expected %0d", credits_available, m_credits);
      end
      checks++;
      if (credit_error !== m_err) begin
         failures++;
         $display("FAIL credit_error: got %b expected %b", credit_error, m_err);
      end
      checks++;
      if (issued_count !== 32'(m_issued)) begin
         failures++;
         $display("FAIL issued_count: got %0d expected %0d", issued_count, m_issued);
      end
      @(negedge clock);
   endtask

   task automatic check_reset_outputs(input string where);
      checks++;
      if (command_valid !== 1'b0 || command_payload !== '0 || command_tag !== 8'd0 ||
          command_src !== 2'd0 || credits_available !== 7'd64 || issued_count !== 32'd0 ||
          credit_error !== 1'b0 || req_grant !== 4'b0000) begin
         failures++;
         $display("FAIL %s: got cv=%b tag=%0d src=%0d cred=%0d iss=%0d err=%b grant=%b payload_nz=%b expected reset values",
                  where, command_valid, command_tag, command_src, credits_available,
                  issued_count, credit_error, req_grant, |command_payload);
      end
   endtask

   task automatic test_reset();
      rstn           = 1'b0;
      enabled_in     = 1'b1;
      req_valid      = 4'b1111;
      req_cmd        = '1;
      response_valid = 1'b0;
      model_reset();
      @(negedge clock);
      #1;
      check_reset_outputs("reset_state");
      req_valid  = '0;
      enabled_in = 1'b0;
      @(negedge clock);
      rstn = 1'b1;
   endtask

   task automatic test_rr_pair();
      int exp_src[4] = '{1, 2, 1, 2};
      test_reset();
      for (int i = 0; i < 8; i++) cycle(4'b0110, 1'b1, 1'b0);
      checks++;
      if (src_log.size() != 8) begin
         failures++;
         $display("FAIL rr_pair_issue_count: got %0d expected 8", src_log.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (src_log[i] != exp_src[i] || tag_log[i] != i) begin
               failures++;
               $display("FAIL rr_pair_seq[%0d]: got src=%0d tag=%0d expected src=%0d tag=%0d",
                        i, src_log[i], tag_log[i], exp_src[i], i);
            end
         end
      end
   endtask

   task automatic test_all_four();
`ifdef CMD_ARB_WED_PRIORITY_EN
      int exp_src[5] = '{0, 0, 0, 0, 0};
`else
      int exp_src[5] = '{0, 1, 2, 3, 0};
`endif
      test_reset();
      for (int i = 0; i < 5; i++) cycle(4'b1111, 1'b1, 1'b0);
      checks++;
      if (src_log.size() != 5) begin
         failures++;
         $display("FAIL all_four_count: got %0d expected 5", src_log.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (src_log[i] != exp_src[i]) begin
               failures++;
               $display("FAIL all_four_order[%0d]: got %0d expected %0d", i, src_log[i], exp_src[i]);
            end
         end
      end
   endtask

   task automatic test_credit_exhaust();
      test_reset();
      for (int i = 0; i < 70; i++) cycle(4'b0010, 1'b1, 1'b0);
      checks++;
      if (src_log.size() != 64 || credits_available !== 7'd0) begin
         failures++;
         $display("FAIL credit_exhaust: got issues=%0d credits=%0d expected issues=64 credits=0",
                  src_log.size(), credits_available);
      end
      cycle(4'b0010, 1'b1, 1'b1);
      checks++;
      if (src_log.size() != 64 || credits_available !== 7'd1) begin
         failures++;
         $display("FAIL credit_return: got issues=%0d credits=%0d expected issues=64 credits=1",
                  src_log.size(), credits_available);
      end
      cycle(4'b0010, 1'b1, 1'b0);
      checks++;
      if (src_log.size() != 65 || credits_available !== 7'd0) begin
         failures++;
         $display("FAIL credit_regrant: got issues=%0d credits=%0d expected issues=65 credits=0",
                  src_log.size(), credits_available);
      end
   endtask

   task automatic test_tag_wrap_and_balance();
      test_reset();
      for (int i = 0; i < 300; i++) cycle(4'b0100, 1'b1, 1'b1);
      checks++;
      if (issued_count !== 32'd300 || tag_log.size() != 300) begin
         failures++;
         $display("FAIL issued_300: got %0d (log %0d) expected 300", issued_count, tag_log.size());
      end else begin
         checks++;
         if (tag_log[255] != 255 || tag_log[256] != 0 || tag_log[299] != 43) begin
            failures++;
            $display("FAIL tag_wrap: got %0d,%0d,%0d expected 255,0,43",
                     tag_log[255], tag_log[256], tag_log[299]);
         end
      end
      test_reset();
      for (int i = 0; i < 54; i++) cycle(4'b0100, 1'b1, 1'b0);
      checks++;
      if (credits_available !== 7'd10) begin
         failures++;
         $display("FAIL credits_at_10: got %0d expected 10", credits_available);
      end
      cycle(4'b0100, 1'b1, 1'b1);
      checks++;
      if (credits_available !== 7'd10 || issued_count !== 32'd55) begin
         failures++;
         $display("FAIL grant_and_response: got credits=%0d issued=%0d expected 10 and 55",
                  credits_available, issued_count);
      end
   endtask

   task automatic test_credit_error_and_midreset();
      test_reset();
      cycle(4'b0000, 1'b1, 1'b1);
      checks++;
      if (credit_error !== 1'b1 || credits_available !== 7'd64) begin
         failures++;
         $display("FAIL credit_error_set: got err=%b credits=%0d expected 1 and 64",
                  credit_error, credits_available);
      end
      for (int i = 0; i < 3; i++) cycle(4'b1111, 1'b1, 1'b0);
      checks++;
      if (command_valid !== 1'b1 || credit_error !== 1'b1) begin
         failures++;
         $display("FAIL pre_midreset: got cv=%b err=%b expected 1 and 1", command_valid, credit_error);
      end
      // inputs still requesting; assert reset between clock edges
      #2;
      rstn = 1'b0;
      #1;
      check_reset_outputs("midstream_reset");
      test_reset();
      cycle(4'b0001, 1'b1, 1'b0);
   endtask

   task automatic test_disabled();
      test_reset();
      for (int i = 0; i < 3; i++) cycle(4'b1111, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) cycle(4'b1111, 1'b0, logic'(i % 2));
      checks++;
      if (src_log.size() != 3 || credits_available !== 7'd64) begin
         failures++;
         $display("FAIL disabled_interval: got issues=%0d credits=%0d expected 3 and 64",
                  src_log.size(), credits_available);
      end
      for (int i = 0; i < 3; i++) cycle(4'b1111, 1'b1, 1'b0);
      checks++;
      if (src_log.size() != 6) begin
         failures++;
         $display("FAIL reenable: got issues=%0d expected 6", src_log.size());
      end
   endtask

   initial begin
      test_reset();
      test_rr_pair();
      test_all_four();
      test_credit_exhaust();
      test_tag_wrap_and_balance();
      test_credit_error_and_midreset();
      test_disabled();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
